// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC sequencer with 2-entry fetch queue, redirect flush and halt (optional FETCH_PERF_EN counters)
module fetch_controller #(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_req,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               if_ready,
    output logic               halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetch_cnt,
    output logic [15:0]        perf_stall_cnt
`endif
);

    typedef enum logic {RUN, HALT} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc;
    logic [1:0]          count;
    logic [1:0]          fill;
    logic [ADDR_W-1:0]   q_pc0, q_pc1;
    logic [INSTR_W-1:0]  q_instr0, q_instr1;
    logic                pop, push;

    assign imem_addr = pc;
    assign if_valid  = (count != 2'd0);
    assign if_pc     = q_pc0;
    assign if_instr  = q_instr0;
    assign halted    = (state == HALT);

    assign pop  = if_valid && if_ready;
    assign push = (state == RUN) && !redirect_valid && ((count < 2'd2) || pop);
    // Slot the incoming word lands in, after any same-cycle pop has shifted the queue
    assign fill = count - {1'b0, pop};

    always_comb begin
        state_nxt = state;
        if (redirect_valid)
            state_nxt = RUN;
        else if (halt_req)
            state_nxt = HALT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            count    <= 2'd0;
            q_pc0    <= '0;
            q_pc1    <= '0;
            q_instr0 <= '0;
            q_instr1 <= '0;
        end else if (redirect_valid) begin
            // Flush: a same-cycle pop is still consumed by decode, nothing is kept
            count <= 2'd0;
            pc    <= redirect_pc & ~ADDR_W'(1);
        end else begin
            if (pop) begin
                q_pc0    <= q_pc1;
                q_instr0 <= q_instr1;
            end
            if (push) begin
                if (fill == 2'd0) begin
                    q_pc0    <= pc;
                    q_instr0 <= imem_instr;
                end else begin
                    q_pc1    <= pc;
                    q_instr1 <= imem_instr;
                end
                pc <= pc + ADDR_W'(PC_STEP);
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= 16'd0;
            perf_stall_cnt <= 16'd0;
        end else begin
            if (push)
                perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
            if ((state == RUN) && (count == 2'd2) && !pop)
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - randomized and directed bench for fetch_controller against a queue-based model
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        halt_req = 1'b0;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        if_ready = 1'b0;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: instruction queue of {pc, instr}, next fetch pc, halted flag
    logic [31:0] mq[$];
    logic [15:0] mpc;
    logic        mhalt;
    logic [15:0] mfetch, mstall;

    always #5 clk = ~clk;

    assign imem_instr = imem_addr >> 1;

    fetch_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .halted         (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    task automatic model_reset();
        mq.delete();
        mpc    = 16'h0000;
        mhalt  = 1'b0;
        mfetch = 16'd0;
        mstall = 16'd0;
    endtask

    // Drive one cycle from just after a falling edge; advance the model at the rising edge
    task automatic drive_cycle(input logic rdy, input logic rv, input logic [15:0] rpc, input logic hr);
        bit pop, push;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = hr;
        @(posedge clk);
        pop  = (mq.size() != 0) && rdy;
        push = !mhalt && !rv && ((mq.size() < 2) || pop);
        if (!mhalt && mq.size() == 2 && !pop) mstall = mstall + 16'd1;
        if (pop) void'(mq.pop_front());
        if (rv) begin
            mq.delete();
            mpc   = {rpc[15:1], 1'b0};
            mhalt = 1'b0;
        end else begin
            if (push) begin
                mq.push_back({mpc, 1'b0, mpc[15:1]});
                mpc    = mpc + 16'd2;
                mfetch = mfetch + 16'd1;
            end
            if (hr) mhalt = 1'b1;
        end
        @(negedge clk);
        if_ready = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({if_valid, if_pc, if_instr, halted, imem_addr} !== 50'h0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b pc=%h instr=%h halted=%b addr=%h, want all zero",
                     if_valid, if_pc, if_instr, halted, imem_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        drive_cycle(1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (if_valid !== 1'b1 || if_pc !== 16'(2 * i) || if_instr !== 16'(i)) begin
                n_fail++;
                $display("FAIL stream[%0d]: got valid=%b pc=%h instr=%h, want 1 %h %h",
                         i, if_valid, if_pc, if_instr, 16'(2 * i), 16'(i));
            end
            drive_cycle(1'b1, 1'b0, 16'h0, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (5) drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        n_cmp++;
        if (imem_addr !== 16'h0004 || if_valid !== 1'b1 || mq.size() != 2) begin
            n_fail++;
            $display("FAIL backpressure_hold: got addr=%h valid=%b, want 0004 1", imem_addr, if_valid);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (if_pc !== 16'(2 * i) || if_instr !== 16'(i)) begin
                n_fail++;
                $display("FAIL backpressure_drain[%0d]: got pc=%h instr=%h, want %h %h",
                         i, if_pc, if_instr, 16'(2 * i), 16'(i));
            end
            drive_cycle(1'b1, 1'b0, 16'h0, 1'b0);
        end
    endtask

    task automatic test_redirect();
        repeat (3) drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        drive_cycle(1'b0, 1'b1, 16'h0030, 1'b0);
        n_cmp++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_flush: got valid=%b, want 0", if_valid);
        end
        drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        n_cmp++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0030 || if_instr !== 16'd24) begin
            n_fail++;
            $display("FAIL redirect_target: got valid=%b pc=%h instr=%h, want 1 0030 0018", if_valid, if_pc, if_instr);
        end
        drive_cycle(1'b1, 1'b1, 16'h0031, 1'b0);
        drive_cycle(1'b1, 1'b0, 16'h0, 1'b0);
        n_cmp++;
        if (if_pc !== 16'h0030 || if_instr !== 16'd24) begin
            n_fail++;
            $display("FAIL redirect_odd: got pc=%h instr=%h, want 0030 0018", if_pc, if_instr);
        end
        drive_cycle(1'b1, 1'b1, 16'hFFFE, 1'b0);
        drive_cycle(1'b1, 1'b0, 16'h0, 1'b0);
        n_cmp++;
        if (imem_addr !== 16'h0000 || if_pc !== 16'hFFFE || if_instr !== 16'h7FFF) begin
            n_fail++;
            $display("FAIL redirect_wrap: got addr=%h pc=%h instr=%h, want 0000 fffe 7fff", imem_addr, if_pc, if_instr);
        end
    endtask

    task automatic test_halt();
        do_reset();
        repeat (4) drive_cycle(1'b1, 1'b0, 16'h0, 1'b0);
        drive_cycle(1'b1, 1'b0, 16'h0, 1'b1);
        n_cmp++;
        if (halted !== 1'b1 || imem_addr !== 16'h000A) begin
            n_fail++;
            $display("FAIL halt_enter: got halted=%b addr=%h, want 1 000a", halted, imem_addr);
        end
        repeat (4) drive_cycle(1'b1, 1'b0, 16'h0, 1'b0);
        n_cmp++;
        if (if_valid !== 1'b0 || imem_addr !== 16'h000A || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_drain: got valid=%b addr=%h halted=%b, want 0 000a 1", if_valid, imem_addr, halted);
        end
        drive_cycle(1'b1, 1'b1, 16'h0004, 1'b0);
        drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        n_cmp++;
        if (halted !== 1'b0 || if_valid !== 1'b1 || if_instr !== 16'd2) begin
            n_fail++;
            $display("FAIL halt_resume: got halted=%b valid=%b instr=%h, want 0 1 0002", halted, if_valid, if_instr);
        end
        drive_cycle(1'b1, 1'b1, 16'h0010, 1'b1);
        n_cmp++;
        if (halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_vs_redirect: got halted=%b, want 0", halted);
        end
    endtask

    task automatic test_reset_mid();
        repeat (3) drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (if_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid: got valid=%b halted=%b addr=%h, want 0 0 0000", if_valid, halted, imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        n_cmp++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0000 || imem_addr !== 16'h0002) begin
            n_fail++;
            $display("FAIL reset_restart: got valid=%b pc=%h addr=%h, want 1 0000 0002", if_valid, if_pc, imem_addr);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        repeat (10) drive_cycle(1'b1, 1'b0, 16'h0, 1'b0);
        n_cmp++;
        if (perf_fetch_cnt !== 16'd10 || perf_stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL perf_fetch: got fetch=%0d stall=%0d, want 10 0", perf_fetch_cnt, perf_stall_cnt);
        end
        repeat (4) drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        n_cmp++;
        if (perf_fetch_cnt !== 16'd11 || perf_stall_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL perf_stall: got fetch=%0d stall=%0d, want 11 3", perf_fetch_cnt, perf_stall_cnt);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] head;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                        16'($urandom), $urandom_range(0, 11) == 0);
            head = (mq.size() != 0) ? mq[0] : 32'h0;
            n_cmp++;
            if (if_valid !== (mq.size() != 0) || imem_addr !== mpc || halted !== mhalt ||
                (mq.size() != 0 && {if_pc, if_instr} !== head)) begin
                n_fail++;
                $display("FAIL random[%0d]: got valid=%b pc=%h instr=%h addr=%h halted=%b, want %b %h %h %h %b",
                         i, if_valid, if_pc, if_instr, imem_addr, halted,
                         mq.size() != 0, head[31:16], head[15:0], mpc, mhalt);
            end
`ifdef FETCH_PERF_EN
            n_cmp++;
            if (perf_fetch_cnt !== mfetch || perf_stall_cnt !== mstall) begin
                n_fail++;
                $display("FAIL random_perf[%0d]: got fetch=%0d stall=%0d, want %0d %0d",
                         i, perf_fetch_cnt, perf_stall_cnt, mfetch, mstall);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_reset_mid();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
